// File: rtl/risc_v_mike_mem_bus_seq.sv
// Load/store bus sequencer: decodes a core access into one of several slave
// regions, drives a shared command bus until the slave acks or the wait
// budget runs out, then returns one aligned/extended response strobe.
module risc_v_mike_mem_bus_seq #(
  parameter int ADDR_W         = 32,
  parameter int NUM_REGIONS    = 4,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE =
    {32'hFFFF_0000, 32'h7FFF_F000, 32'h1001_0000, 32'h0040_0000},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK =
    {32'hFFFF_FF00, 32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_0000},
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [2:0]               req_funct3,
  input  logic [31:0]              req_wdata,
  output logic                     rsp_valid,
  output logic [31:0]              rsp_rdata,
  output logic                     rsp_err,
  output logic [NUM_REGIONS-1:0]   slv_req,
  output logic                     slv_we,
  output logic [ADDR_W-1:0]        slv_addr,
  output logic [3:0]               slv_be,
  output logic [31:0]              slv_wdata,
  input  logic [NUM_REGIONS*32-1:0] slv_rdata,
  input  logic [NUM_REGIONS-1:0]   slv_ack
);

  // state  | meaning
  // IDLE   | ready for a request, bus quiet
  // ACCESS | slave selected, waiting for its ack or the wait budget
  // RESP   | one-cycle response strobe
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       hit_idx_q, hit_idx_d;
  logic                   write_q, write_d;
  logic [2:0]             funct3_q, funct3_d;
  logic [1:0]             addr_lo_q, addr_lo_d;
  logic [NUM_REGIONS-1:0] slv_req_q, slv_req_d;
  logic                   slv_we_q, slv_we_d;
  logic [ADDR_W-1:0]      slv_addr_q, slv_addr_d;
  logic [3:0]             slv_be_q, slv_be_d;
  logic [31:0]            slv_wdata_q, slv_wdata_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [31:0]            rsp_rdata_q, rsp_rdata_d;
  logic                   rsp_err_q, rsp_err_d;

  logic                   hit_found;
  logic [IDX_W-1:0]       hit_idx;
  logic [NUM_REGIONS-1:0] hit_onehot;
  logic                   f3_ok;
  logic                   misalign;
  logic [3:0]             cmd_be;
  logic [31:0]            cmd_wdata;
  logic                   ack_sel;
  logic [31:0]            sel_rdata;
  logic [31:0]            lane;
  logic [31:0]            load_data;

  // Ready only while idle; forced low for the whole time reset is held.
  assign req_ready = rst && (state_q == S_IDLE);

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign slv_req   = slv_req_q;
  assign slv_we    = slv_we_q;
  assign slv_addr  = slv_addr_q;
  assign slv_be    = slv_be_q;
  assign slv_wdata = slv_wdata_q;

  // Request decode: region lookup (lowest index wins), funct3 legality,
  // alignment, and byte-lane formatting of the store command.
  always_comb begin
    hit_found  = 1'b0;
    hit_idx    = '0;
    hit_onehot = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (!hit_found &&
          ((req_addr & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W])) begin
        hit_found     = 1'b1;
        hit_idx       = IDX_W'(i);
        hit_onehot[i] = 1'b1;
      end
    end

    case (req_funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = !req_write;
      default:                f3_ok = 1'b0;
    endcase

    misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
               ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

    case (req_funct3[1:0])
      2'b00: begin
        cmd_be    = 4'b0001 << req_addr[1:0];
        cmd_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        cmd_be    = 4'b0011 << req_addr[1:0];
        cmd_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        cmd_be    = 4'b1111;
        cmd_wdata = req_wdata;
      end
    endcase
  end

  // Load return path: pick the selected slave's word, shift the addressed
  // lane down, then sign- or zero-extend by access type.
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (hit_idx_q == IDX_W'(i)) sel_rdata = slv_rdata[i*32 +: 32];
    end
    ack_sel = |(slv_ack & slv_req_q);
    lane    = sel_rdata >> {addr_lo_q, 3'b000};
    case (funct3_q)
      3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_data = {24'h0, lane[7:0]};
      3'b101:  load_data = {16'h0, lane[15:0]};
      default: load_data = sel_rdata;
    endcase
  end

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hit_idx_d   = hit_idx_q;
    write_d     = write_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    slv_req_d   = slv_req_q;
    slv_we_d    = slv_we_q;
    slv_addr_d  = slv_addr_q;
    slv_be_d    = slv_be_q;
    slv_wdata_d = slv_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d     = req_write;
          funct3_d    = req_funct3;
          addr_lo_d   = req_addr[1:0];
          slv_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
          slv_wdata_d = cmd_wdata;
          if (f3_ok && !misalign && hit_found) begin
            state_d   = S_ACCESS;
            cnt_d     = '0;
            hit_idx_d = hit_idx;
            slv_req_d = hit_onehot;
            slv_we_d  = req_write;
            slv_be_d  = cmd_be;
          end else begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end
      S_ACCESS: begin
        if (ack_sel || (cnt_q == CNT_LAST)) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = !ack_sel;
          rsp_rdata_d = (ack_sel && !write_q) ? load_data : 32'h0;
          slv_req_d   = '0;
          slv_we_d    = 1'b0;
          slv_be_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears the slave request at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hit_idx_q   <= '0;
      write_q     <= 1'b0;
      funct3_q    <= '0;
      addr_lo_q   <= '0;
      slv_req_q   <= '0;
      slv_we_q    <= 1'b0;
      slv_addr_q  <= '0;
      slv_be_q    <= '0;
      slv_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hit_idx_q   <= hit_idx_d;
      write_q     <= write_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      slv_req_q   <= slv_req_d;
      slv_we_q    <= slv_we_d;
      slv_addr_q  <= slv_addr_d;
      slv_be_q    <= slv_be_d;
      slv_wdata_q <= slv_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_risc_v_mike_mem_bus_seq.sv
// Bench for the load/store bus sequencer: directed vector table, reset and
// back-to-back sequences, then random traffic against a behavioural model.
module tb_risc_v_mike_mem_bus_seq;

  localparam int TO = 16;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [31:0]  req_addr;
  logic [2:0]   req_funct3;
  logic [31:0]  req_wdata;
  logic         rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  logic [3:0]   slv_req;
  logic         slv_we;
  logic [31:0]  slv_addr;
  logic [3:0]   slv_be;
  logic [31:0]  slv_wdata;
  logic [127:0] slv_rdata;
  logic [3:0]   slv_ack;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] tb_base [4] = '{32'h0040_0000, 32'h1001_0000, 32'h7FFF_F000, 32'hFFFF_0000};
  logic [31:0] tb_mask [4] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_FF00};

  risc_v_mike_mem_bus_seq dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .slv_req(slv_req), .slv_we(slv_we), .slv_addr(slv_addr), .slv_be(slv_be),
    .slv_wdata(slv_wdata), .slv_rdata(slv_rdata), .slv_ack(slv_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural reference: expected response and command bus from the access rules.
  function automatic void model(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                                input logic [31:0] wdata, input logic [31:0] sdata, input int lat,
                                output logic err, output logic [31:0] rdata, output logic [3:0] req,
                                output logic [3:0] be, output logic [31:0] wd, output int elat);
    int region;
    int nbytes;
    logic legal;
    logic sgn;
    longint v;
    region = -1;
    for (int i = 0; i < 4; i++)
      if (region < 0 && (addr & tb_mask[i]) == tb_base[i]) region = i;
    legal = 1'b1;
    sgn = 1'b0;
    nbytes = 4;
    case (f3)
      3'd0: begin nbytes = 1; sgn = 1'b1; end
      3'd1: begin nbytes = 2; sgn = 1'b1; end
      3'd2: nbytes = 4;
      3'd4: begin nbytes = 1; legal = !we; end
      3'd5: begin nbytes = 2; legal = !we; end
      default: legal = 1'b0;
    endcase
    if ((addr % nbytes) != 0) legal = 1'b0;
    if (region < 0) legal = 1'b0;
    err = 1'b1; rdata = 0; req = 0; be = 0; wd = 0; elat = 1;
    if (!legal) return;
    req = 4'(1 << region);
    be  = 4'(((1 << nbytes) - 1) << (addr % 4));
    if (nbytes == 1)      wd = (wdata & 32'hFF) * 32'h0101_0101;
    else if (nbytes == 2) wd = (wdata & 32'hFFFF) * 32'h0001_0001;
    else                  wd = wdata;
    if (lat >= TO) begin
      err = 1'b1; rdata = 0; elat = TO + 1;
    end else begin
      err = 1'b0; elat = lat + 2;
      if (we) rdata = 0;
      else begin
        v = longint'(sdata >> (8 * (addr % 4))) & ((64'h1 << (8 * nbytes)) - 1);
        if (sgn && v >= (64'h1 << (8 * nbytes - 1))) v = v - (64'h1 << (8 * nbytes));
        rdata = 32'(v);
      end
    end
  endfunction

  // One full transaction; entered and left on a negedge with the DUT idle.
  // lat = index of the ACCESS cycle in which the slave acks (>=16 never acks).
  task automatic do_access(input string tag, input logic we, input logic [31:0] addr,
                           input logic [2:0] f3, input logic [31:0] wdata, input logic [31:0] sdata,
                           input int lat, input logic exp_err, input logic [31:0] exp_rdata,
                           input logic [3:0] exp_req, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata, input int exp_lat);
    int cyc;
    int req_cycles;
    int got_lat;
    int exp_rc;
    logic bus_ok;
    logic ready_ok;
    logic seen;
    logic [31:0] got_rdata;
    logic got_err;
    logic [3:0] ack;
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = we; req_addr = addr; req_funct3 = f3; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
    cyc = 1; req_cycles = 0; bus_ok = 1'b1; ready_ok = 1'b1; seen = 1'b0;
    got_lat = 0; got_rdata = 0; got_err = 0;
    while (!seen && cyc <= 40) begin
      for (int i = 0; i < 4; i++) slv_rdata[i*32 +: 32] = exp_req[i] ? sdata : $urandom;
      ack = 4'b0;
      if (req_ready) ready_ok = 1'b0;
      if (slv_req != 4'b0) begin
        if (slv_req !== exp_req || slv_we !== we || slv_be !== exp_be ||
            slv_addr !== (addr & 32'hFFFF_FFFC) || (we && slv_wdata !== exp_wdata))
          bus_ok = 1'b0;
        if (req_cycles == lat) ack = exp_req;
        req_cycles++;
      end else if (slv_we || slv_be != 4'b0) begin
        bus_ok = 1'b0;
      end
      slv_ack = ack | (4'($urandom_range(0, 15)) & ~exp_req);
      if (rsp_valid) begin
        seen = 1'b1; got_lat = cyc; got_err = rsp_err; got_rdata = rsp_rdata;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    slv_ack = 4'b0;
    exp_rc = (exp_req == 4'b0) ? 0 : ((lat < TO) ? lat + 1 : TO);
    check({tag, "_rsp_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(got_lat), 32'(exp_lat));
    check({tag, "_err"}, 32'(got_err), 32'(exp_err));
    check({tag, "_rdata"}, got_rdata, exp_rdata);
    check({tag, "_req_cycles"}, 32'(req_cycles), 32'(exp_rc));
    check({tag, "_bus"}, 32'(bus_ok), 32'd1);
    check({tag, "_ready_busy"}, 32'(ready_ok), 32'd1);
    @(negedge clk);
    check({tag, "_rsp_one_cycle"}, {rsp_valid, rsp_err, 30'b0} | rsp_rdata, 32'h0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wdata;
    logic [31:0] sdata;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  req;
    logic [3:0]  be;
    logic [31:0] wd;
    int          elat;
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic        m_err;
    logic [31:0] m_rdata;
    logic [3:0]  m_req;
    logic [3:0]  m_be;
    logic [31:0] m_wd;
    int          m_lat;
    logic        r_we;
    logic [31:0] r_addr;
    logic [2:0]  r_f3;
    logic [31:0] r_wdata;
    logic [31:0] r_sdata;
    int          r_lat;
    int          k;
    logic        flag;
    int          acc_cyc [4];
    int          n_acc;
    int          n_rsp;
    int          idx;
    int          cyc;
    logic        pend;
    logic        rdy_ok;

    vecs[0]  = '{1'b0, 32'h1001_0003, 3'd0, 32'h0,         32'h80FF_FFFF, 0,  1'b0, 32'hFFFF_FF80, 4'b0010, 4'b1000, 32'h0,         2};
    vecs[1]  = '{1'b1, 32'h1001_0002, 3'd1, 32'h0000_ABCD, 32'h0,         0,  1'b0, 32'h0,         4'b0010, 4'b1100, 32'hABCD_ABCD, 2};
    vecs[2]  = '{1'b0, 32'h1001_0002, 3'd2, 32'h0,         32'h0,         0,  1'b1, 32'h0,         4'b0000, 4'b0000, 32'h0,         1};
    vecs[3]  = '{1'b0, 32'h2000_0000, 3'd2, 32'h0,         32'h0,         0,  1'b1, 32'h0,         4'b0000, 4'b0000, 32'h0,         1};
    vecs[4]  = '{1'b0, 32'h0040_0000, 3'd2, 32'h0,         32'h0,         99, 1'b1, 32'h0,         4'b0001, 4'b1111, 32'h0,         17};
    vecs[5]  = '{1'b0, 32'h0040_0004, 3'd2, 32'h0,         32'h1234_5678, 15, 1'b0, 32'h1234_5678, 4'b0001, 4'b1111, 32'h0,         17};
    vecs[6]  = '{1'b0, 32'h7FFF_F001, 3'd4, 32'h0,         32'h0000_AB00, 1,  1'b0, 32'h0000_00AB, 4'b0100, 4'b0010, 32'h0,         3};
    vecs[7]  = '{1'b1, 32'hFFFF_0010, 3'd0, 32'h1234_56EF, 32'h0,         2,  1'b0, 32'h0,         4'b1000, 4'b0001, 32'hEFEF_EFEF, 4};
    vecs[8]  = '{1'b1, 32'h0040_0000, 3'd4, 32'h0000_0011, 32'h0,         0,  1'b1, 32'h0,         4'b0000, 4'b0000, 32'h0,         1};
    vecs[9]  = '{1'b0, 32'h0040_0000, 3'd3, 32'h0,         32'h0,         0,  1'b1, 32'h0,         4'b0000, 4'b0000, 32'h0,         1};
    vecs[10] = '{1'b0, 32'h0040_0002, 3'd1, 32'h0,         32'h8001_5555, 0,  1'b0, 32'hFFFF_8001, 4'b0001, 4'b1100, 32'h0,         2};
    vecs[11] = '{1'b1, 32'h1001_0008, 3'd2, 32'hDEAD_BEEF, 32'h0,         0,  1'b0, 32'h0,         4'b0010, 4'b1111, 32'hDEAD_BEEF, 2};
    vecs[12] = '{1'b0, 32'h0040_0003, 3'd5, 32'h0,         32'h0,         0,  1'b1, 32'h0,         4'b0000, 4'b0000, 32'h0,         1};
    vecs[13] = '{1'b0, 32'h0040_0006, 3'd5, 32'h0,         32'hF00D_1234, 0,  1'b0, 32'h0000_F00D, 4'b0001, 4'b1100, 32'h0,         2};

    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 0; req_funct3 = 0;
    req_wdata = 0; slv_rdata = 0; slv_ack = 0;
    #1;
    check("reset_ready_low", 32'(req_ready), 32'd0);
    check("reset_outputs", {slv_req, slv_we, slv_be, rsp_valid, rsp_err, 21'b0} | rsp_rdata, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_ready", 32'(req_ready), 32'd1);
    check("post_reset_idle", {slv_req, slv_we, slv_be, rsp_valid, rsp_err, 21'b0}, 32'h0);

    for (int i = 0; i < 14; i++)
      do_access($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].f3, vecs[i].wdata,
                vecs[i].sdata, vecs[i].lat, vecs[i].err, vecs[i].rdata, vecs[i].req,
                vecs[i].be, vecs[i].wd, vecs[i].elat);

    // Reset in the middle of an access.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0040_0000; req_funct3 = 3'd2;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_req_before", 32'(slv_req), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("abort_req_dropped", 32'(slv_req), 32'h0);
    check("abort_ready_low", 32'(req_ready), 32'd0);
    flag = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid || slv_req != 4'b0) flag = 1'b1;
    end
    rst = 1'b1;
    @(negedge clk);
    if (rsp_valid) flag = 1'b1;
    check("abort_no_rsp", 32'(flag), 32'd0);
    check("abort_ready_after", 32'(req_ready), 32'd1);
    do_access("lhu_after_reset", 1'b0, 32'h0040_0002, 3'd5, 32'h0, 32'h8001_4321, 0,
              1'b0, 32'h0000_8001, 4'b0001, 4'b1100, 32'h0, 2);

    // Back-to-back LW with req_valid held high and a zero-wait slave.
    n_acc = 0; n_rsp = 0; idx = 0; cyc = 0; pend = 1'b0; rdy_ok = 1'b1;
    while (n_rsp < 4 && cyc < 60) begin
      cyc++;
      if (pend) begin idx++; pend = 1'b0; end
      if (idx < 4) begin
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'd2;
        req_addr = 32'h1001_0000 + 32'(4 * idx);
      end else begin
        req_valid = 1'b0;
      end
      if (req_valid && req_ready) begin
        if (n_acc < 4) acc_cyc[n_acc] = cyc;
        n_acc++;
        pend = 1'b1;
      end
      if ((slv_req != 4'b0 || rsp_valid) && req_ready) rdy_ok = 1'b0;
      slv_ack = slv_req;
      for (int i = 0; i < 4; i++) slv_rdata[i*32 +: 32] = slv_addr ^ 32'h5A5A_0000;
      if (rsp_valid) begin
        check($sformatf("b2b_rdata%0d", n_rsp), rsp_rdata,
              (32'h1001_0000 + 32'(4 * n_rsp)) ^ 32'h5A5A_0000);
        check($sformatf("b2b_err%0d", n_rsp), 32'(rsp_err), 32'd0);
        n_rsp++;
      end
      @(negedge clk);
    end
    req_valid = 1'b0; slv_ack = 4'b0;
    check("b2b_accepts", 32'(n_acc), 32'd4);
    check("b2b_responses", 32'(n_rsp), 32'd4);
    for (int i = 1; i < 4; i++)
      if (i < n_acc) check($sformatf("b2b_spacing%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
    check("b2b_ready_low_busy", 32'(rdy_ok), 32'd1);
    @(negedge clk);

    // Random traffic against the behavioural model.
    for (int t = 0; t < 120; t++) begin
      if ($urandom_range(0, 9) == 0) begin
        r_addr = 32'h2000_0000 | 32'($urandom_range(0, 255));
      end else begin
        k = $urandom_range(0, 3);
        r_addr = tb_base[k] | ($urandom & ~tb_mask[k]);
      end
      k = $urandom_range(0, 11);
      case (k)
        0, 5:  r_f3 = 3'd0;
        1, 6:  r_f3 = 3'd1;
        2, 7:  r_f3 = 3'd2;
        3, 8:  r_f3 = 3'd4;
        4, 9:  r_f3 = 3'd5;
        default: r_f3 = 3'($urandom_range(0, 7));
      endcase
      r_we = 1'($urandom_range(0, 1));
      r_wdata = $urandom;
      r_sdata = $urandom;
      r_lat = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 18) : $urandom_range(0, 3);
      model(r_we, r_addr, r_f3, r_wdata, r_sdata, r_lat, m_err, m_rdata, m_req, m_be, m_wd, m_lat);
      do_access($sformatf("rnd%0d", t), r_we, r_addr, r_f3, r_wdata, r_sdata, r_lat,
                m_err, m_rdata, m_req, m_be, m_wd, m_lat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
